gf8_poly_reduce_seq: RTL and testbench

//  Bit-serial GF(2)[x] divider. Takes a 2W-bit carry-less product {in_hi,in_lo} (as produced by
//  the OKA_* multiplier family) and divides it by the monic field polynomial x^W + POLY.

---
 rtl/gf8_pkg.sv | 30 +++
 rtl/gf8_poly_reduce_seq_if.sv | 35 +++
 rtl/gf8_reduce_step.sv | 26 ++
 rtl/gf8_poly_reduce_seq.sv | 117 +++++++++++
 tb/tb_gf8_poly_reduce_seq.sv | 257 +++++++++++++++++++++++++
 5 files changed

// File: rtl/gf8_pkg.sv
// Shared types and constants for the bit-serial GF(2)[x] reducer.
// Holds the FSM state encoding, the default field width and the single-iteration step function.
package gf8_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int         GF8_W        = 8;
    localparam logic [7:0] GF8_AES_POLY = 8'h1B;

    typedef struct packed {
        logic [GF8_W-1:0] r;
        logic             m;
    } step_t;

    // One long-division iteration: the bit leaving R decides whether the
    // field polynomial (implicit x^W term) is cancelled out of the window.
    function automatic step_t gf_step(input logic [GF8_W-1:0] r,
                                      input logic             b,
                                      input logic [GF8_W-1:0] p);
        step_t s;
        s.m = r[GF8_W-1];
        s.r = {r[GF8_W-2:0], b} ^ (s.m ? p : '0);
        return s;
    endfunction

endpackage

// File: rtl/gf8_poly_reduce_seq_if.sv
// Operand/result handshake bundle for gf8_poly_reduce_seq.
// poly_in exists only when GF8_POLY_RUNTIME_EN is defined.
interface gf8_poly_reduce_seq_if #(
    parameter int W = 8
);
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_hi;
    logic [W-1:0] in_lo;
`ifdef GF8_POLY_RUNTIME_EN
    logic [W-1:0] poly_in;
`endif
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_rem;
    logic [W-1:0] out_quo;
    logic         busy;

    modport master (
`ifdef GF8_POLY_RUNTIME_EN
        output poly_in,
`endif
        output in_valid, in_hi, in_lo, out_ready,
        input  in_ready, out_valid, out_rem, out_quo, busy
    );

    modport slave (
`ifdef GF8_POLY_RUNTIME_EN
        input  poly_in,
`endif
        input  in_valid, in_hi, in_lo, out_ready,
        output in_ready, out_valid, out_rem, out_quo, busy
    );

endinterface

// File: rtl/gf8_reduce_step.sv
// Combinational single iteration of the serial divider: (R, L msb, P) -> (R', quotient bit).
module gf8_reduce_step
    import gf8_pkg::*;
#(
    parameter int W = GF8_W
) (
    input  logic [W-1:0] r_in,
    input  logic         l_msb,
    input  logic [W-1:0] poly,
    output logic [W-1:0] r_out,
    output logic         m_out
);

    generate
        if (W == GF8_W) begin : g_pkg_step
            step_t step;
            assign step  = gf_step(r_in, l_msb, poly);
            assign r_out = step.r;
            assign m_out = step.m;
        end else begin : g_generic_step
            assign m_out = r_in[W-1];
            assign r_out = {r_in[W-2:0], l_msb} ^ (m_out ? poly : '0);
        end
    endgenerate

endmodule

// File: rtl/gf8_poly_reduce_seq.sv
// Bit-serial divider of a 2W-bit carry-less product by x^W + POLY, one quotient bit per clock.
// Define GF8_POLY_RUNTIME_EN to take the polynomial from poly_in, sampled at accept.
module gf8_poly_reduce_seq
    import gf8_pkg::*;
#(
    parameter int           W    = GF8_W,
    parameter logic [W-1:0] POLY = W'(GF8_AES_POLY)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    gf8_poly_reduce_seq_if.slave  bus
);

    localparam int             CW       = (W > 1) ? $clog2(W) : 1;
    localparam logic [CW-1:0]  CNT_LAST = CW'(W - 1);

    state_t        state_q, state_d;
    logic [W-1:0]  r_q, r_d;
    logic [W-1:0]  l_q, l_d;
    logic [W-1:0]  q_q, q_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [W-1:0]  p_cur;
    logic [W-1:0]  r_step;
    logic          m_step;
    logic          accept;

    assign accept = (state_q == IDLE) && bus.in_valid;

`ifdef GF8_POLY_RUNTIME_EN
    // Polynomial is latched at accept so poly_in may change freely mid-operation.
    logic [W-1:0] p_q, p_d;

    always_comb begin
        p_d = p_q;
        if (accept) begin
            p_d = bus.poly_in;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            p_q <= POLY;
        end else begin
            p_q <= p_d;
        end
    end

    assign p_cur = p_q;
`else
    assign p_cur = POLY;
`endif

    gf8_reduce_step #(
        .W (W)
    ) u_step (
        .r_in  (r_q),
        .l_msb (l_q[W-1]),
        .poly  (p_cur),
        .r_out (r_step),
        .m_out (m_step)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            r_q     <= '0;
            l_q     <= '0;
            q_q     <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            r_q     <= r_d;
            l_q     <= l_d;
            q_q     <= q_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.in_valid)      state_d = RUN;
            RUN:     if (cnt_q == CNT_LAST) state_d = DONE;
            DONE:    if (bus.out_ready)     state_d = IDLE;
            default:                        state_d = IDLE;
        endcase
    end

    // Working registers only move on accept and during RUN; elsewhere they
    // hold, which keeps the result stable in DONE and after it in IDLE.
    always_comb begin
        r_d   = r_q;
        l_d   = l_q;
        q_d   = q_q;
        cnt_d = cnt_q;
        if (accept) begin
            r_d   = bus.in_hi;
            l_d   = bus.in_lo;
            q_d   = '0;
            cnt_d = '0;
        end else if (state_q == RUN) begin
            r_d   = r_step;
            l_d   = l_q << 1;
            q_d   = {q_q[W-2:0], m_step};
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_comb begin
        bus.in_ready  = (state_q == IDLE);
        bus.out_valid = (state_q == DONE);
        bus.busy      = (state_q == RUN) || (state_q == DONE);
        bus.out_rem   = r_q;
        bus.out_quo   = q_q;
    end

endmodule

// File: tb/tb_gf8_poly_reduce_seq.sv
// Self-checking bench for gf8_poly_reduce_seq: directed vectors, backpressure, mid-run reset
// and randomized operands checked against a brute-force quotient-search reference model.
module tb_gf8_poly_reduce_seq;

    logic clk;
    logic rst_n;
    int   cyc;
    int   checks;
    int   errors;
    bit   rand_ready;

    typedef struct {
        logic [7:0] rem;
        logic [7:0] quo;
        int         acc;
        bit         seen;
    } exp_t;

    exp_t exp_q[$];

    gf8_poly_reduce_seq_if #(.W(8)) bus ();

    gf8_poly_reduce_seq dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

`ifdef GF8_POLY_RUNTIME_EN
    localparam logic [7:0] DEF_POLY = 8'h1B;
`else
    localparam logic [7:0] DEF_POLY = 8'h1B;
`endif

    // Reference: search the quotient q so that D xor q*(x^8+P) has degree < 8.
    function automatic logic [15:0] model_div(input logic [15:0] d, input logic [7:0] p);
        logic [15:0] prod;
        logic [15:0] dv;
        logic [15:0] rr;
        dv = {7'd0, 1'b1, p};
        for (int q = 0; q < 256; q++) begin
            prod = '0;
            for (int i = 0; i < 8; i++) begin
                if (q[i]) prod = prod ^ (dv << i);
            end
            rr = d ^ prod;
            if (rr < 16'h0100) return {q[7:0], rr[7:0]};
        end
        return 16'h0000;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Compare process: every cycle with out_valid the result must match the model head.
    always @(negedge clk) begin
        if (rst_n && bus.out_valid) begin
            if (exp_q.size() == 0) begin
                check("spurious_out_valid", 32'(bus.out_valid), 32'd0);
            end else begin
                if (!exp_q[0].seen) begin
                    check("accept_to_valid", 32'(cyc), 32'(exp_q[0].acc + 9));
                    exp_q[0].seen = 1'b1;
                end
                check("out_rem", 32'(bus.out_rem), 32'(exp_q[0].rem));
                check("out_quo", 32'(bus.out_quo), 32'(exp_q[0].quo));
                check("in_ready_in_done", 32'(bus.in_ready), 32'd0);
                check("busy_in_done", 32'(bus.busy), 32'd1);
                if (bus.out_ready) void'(exp_q.pop_front());
            end
        end
    end

    always @(posedge clk) begin
        #1;
        if (rand_ready) bus.out_ready = 1'($urandom_range(0, 1));
    end

    task automatic drive_ready(input logic v);
        @(posedge clk);
        #1;
        bus.out_ready = v;
    endtask

    task automatic send(input logic [7:0] hi, input logic [7:0] lo, input logic [7:0] p);
        int n;
        logic [15:0] res;
        n = 0;
        @(negedge clk);
        while (!bus.in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!bus.in_ready) begin
            check("send_timeout", 32'(bus.in_ready), 32'd1);
            return;
        end
        bus.in_valid = 1'b1;
        bus.in_hi    = hi;
        bus.in_lo    = lo;
`ifdef GF8_POLY_RUNTIME_EN
        bus.poly_in  = p;
`endif
        res = model_div({hi, lo}, p);
        exp_q.push_back('{rem: res[7:0], quo: res[15:8], acc: cyc, seen: 1'b0});
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.in_hi    = 8'($urandom);
        bus.in_lo    = 8'($urandom);
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((exp_q.size() != 0 || !bus.in_ready) && n < 500) begin
            @(negedge clk);
            n++;
        end
        check("wait_idle_timeout", 32'(exp_q.size()), 32'd0);
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_in_ready"},  32'(bus.in_ready),  32'd1);
        check({tag, "_out_valid"}, 32'(bus.out_valid), 32'd0);
        check({tag, "_busy"},      32'(bus.busy),      32'd0);
        check({tag, "_out_rem"},   32'(bus.out_rem),   32'd0);
        check({tag, "_out_quo"},   32'(bus.out_quo),   32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] r;
        int n;
        checks       = 0;
        errors       = 0;
        rand_ready   = 1'b0;
        rst_n        = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_hi    = '0;
        bus.in_lo    = '0;
        bus.out_ready = 1'b1;
`ifdef GF8_POLY_RUNTIME_EN
        bus.poly_in  = 8'h1B;
`endif

        // Pin the reference model with hand-computed values.
        r = model_div(16'h2B79, 8'h1B); check("model_aes", 32'(r), 32'h28C1);
        r = model_div(16'h00A5, 8'h1B); check("model_noreduce", 32'(r), 32'h00A5);
        r = model_div(16'h0100, 8'h1B); check("model_x8", 32'(r), 32'h011B);
        r = model_div(16'h0100, 8'h1D); check("model_x8_1d", 32'(r), 32'h011D);

        repeat (3) @(negedge clk);
        check_reset_state("reset");
        rst_n = 1'b1;

        // Directed vectors.
        send(8'h2B, 8'h79, DEF_POLY); wait_idle();
        check("aes_rem_held_idle", 32'(bus.out_rem), 32'hC1);
        check("aes_quo_held_idle", 32'(bus.out_quo), 32'h28);
        send(8'h00, 8'hA5, DEF_POLY); wait_idle();
        send(8'h01, 8'h00, DEF_POLY); wait_idle();
        send(8'hFF, 8'hFF, DEF_POLY); wait_idle();

        // Backpressure: result held, inputs ignored while DONE.
        drive_ready(1'b0);
        send(8'h2B, 8'h79, DEF_POLY);
        n = 0;
        while (!bus.out_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("bp_valid_seen", 32'(bus.out_valid), 32'd1);
        for (int k = 0; k < 5; k++) begin
            @(posedge clk);
            #1;
            bus.in_valid = (k < 3) && (k % 2 == 0);
            bus.in_hi    = 8'($urandom);
            bus.in_lo    = 8'($urandom);
            @(negedge clk);
            check("bp_in_ready_low", 32'(bus.in_ready), 32'd0);
            check("bp_out_valid_high", 32'(bus.out_valid), 32'd1);
        end
        @(posedge clk);
        #1;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        @(negedge clk);
        drive_ready(1'b0);
        @(negedge clk);
        check("bp_back_idle_ready", 32'(bus.in_ready), 32'd1);
        check("bp_back_idle_valid", 32'(bus.out_valid), 32'd0);
        check("bp_model_drained", 32'(exp_q.size()), 32'd0);
        drive_ready(1'b1);

        // Reset in the middle of RUN discards the operation.
        send(8'hC3, 8'h5A, DEF_POLY);
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        exp_q.delete();
        #1;
        check_reset_state("midrun_reset");
        @(negedge clk);
        check_reset_state("midrun_reset_hold");
        rst_n = 1'b1;
        send(8'h2B, 8'h79, DEF_POLY); wait_idle();

`ifdef GF8_POLY_RUNTIME_EN
        // Runtime polynomial, sampled only at accept.
        send(8'h01, 8'h00, 8'h1D);
        for (int k = 0; k < 5; k++) begin
            bus.poly_in = 8'($urandom);
            @(negedge clk);
        end
        wait_idle();
        check("runtime_poly_rem", 32'(bus.out_rem), 32'h1D);
        bus.poly_in = 8'h1B;
`endif

        // Randomized operands with random consumer backpressure.
        rand_ready = 1'b1;
        for (int t = 0; t < 40; t++) begin
            logic [7:0] p;
`ifdef GF8_POLY_RUNTIME_EN
            p = 8'($urandom);
`else
            p = DEF_POLY;
`endif
            send(8'($urandom), 8'($urandom), p);
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end
        wait_idle();
        rand_ready = 1'b0;
        drive_ready(1'b1);
        repeat (2) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

endmodule
